// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the timer register-bus master: op codes, timer register
// map, control/status bit positions and the controller state encoding.
package timer_ctrl_pkg;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_STOP  = 2'd1;
    localparam logic [1:0] OP_SNAP  = 2'd2;
    localparam logic [1:0] OP_WAIT  = 2'd3;

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
    localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
    localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

    localparam int STATUS_TO_BIT  = 0;
    localparam int STATUS_RUN_BIT = 1;
    localparam int CTRL_ITO_BIT   = 0;
    localparam int CTRL_CONT_BIT  = 1;
    localparam int CTRL_START_BIT = 2;
    localparam int CTRL_STOP_BIT  = 3;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        RD_DATA,
        GAP,
        IRQ_WAIT,
        CLR,
        DONE
    } state_t;

    function automatic logic [15:0] ctrl_word(input logic start, input logic stop,
                                              input logic cont, input logic ito);
        logic [15:0] w;
        w                 = '0;
        w[CTRL_ITO_BIT]   = ito;
        w[CTRL_CONT_BIT]  = cont;
        w[CTRL_START_BIT] = start;
        w[CTRL_STOP_BIT]  = stop;
        return w;
    endfunction

endpackage

// File: rtl/timer_ctrl_master.sv
// Command-driven bus master for a simple interval timer (START/STOP/SNAP/WAIT).
// Optional macro TIMER_CTRL_IRQ_WAIT_EN: WAIT blocks on irq instead of polling when ito is set.
module timer_ctrl_master #(
    parameter int POLL_GAP = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_period,
    input  logic        cmd_cont,
    input  logic        cmd_ito,
    output logic        done,
    output logic [31:0] rsp_data,
    output logic [2:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [15:0] avm_writedata,
    input  logic [15:0] avm_readdata,
    input  logic        irq
);
    import timer_ctrl_pkg::*;

    localparam logic [7:0] GAP_LAST = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);

    state_t      state, state_next;
    logic [1:0]  step, step_next;
    logic [7:0]  gap_cnt, gap_next;
    logic [1:0]  op_q;
    logic [31:0] period_q;
    logic        cont_q, ito_q;
    logic [15:0] snap_lo;
    logic        irq_wait_active;
    logic        accept;

`ifdef TIMER_CTRL_IRQ_WAIT_EN
    assign irq_wait_active = ito_q;
`else
    assign irq_wait_active = 1'b0;
`endif

    assign cmd_ready = reset_n && (state == IDLE);
    assign accept    = cmd_valid && (state == IDLE);
    assign done      = (state == DONE);

    always_comb begin
        state_next     = state;
        step_next      = step;
        gap_next       = gap_cnt;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = '0;
        avm_writedata  = '0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    step_next = '0;
                    if (cmd_op == OP_WAIT)
                        state_next = irq_wait_active ? IRQ_WAIT : RD_ADDR;
                    else
                        state_next = WRITE;
                end
            end
            WRITE: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                step_next      = '0;
                case (op_q)
                    OP_START: begin
                        case (step)
                            2'd0: begin
                                avm_address   = ADDR_PERIOD_L;
                                avm_writedata = period_q[15:0];
                            end
                            2'd1: begin
                                avm_address   = ADDR_PERIOD_H;
                                avm_writedata = period_q[31:16];
                            end
                            2'd2: avm_address = ADDR_STATUS;
                            default: begin
                                avm_address   = ADDR_CONTROL;
                                avm_writedata = ctrl_word(1'b1, 1'b0, cont_q, ito_q);
                            end
                        endcase
                        if (step == 2'd3)
                            state_next = DONE;
                        else
                            step_next = step + 2'd1;
                    end
                    OP_STOP: begin
                        avm_address   = ADDR_CONTROL;
                        avm_writedata = ctrl_word(1'b0, 1'b1, cont_q, ito_q);
                        state_next    = DONE;
                    end
                    OP_SNAP: begin
                        avm_address = ADDR_SNAP_L;
                        state_next  = RD_ADDR;
                    end
                    default: state_next = DONE;
                endcase
            end
            // SNAP issues back-to-back reads of snap_l then snap_h; WAIT reads status once.
            RD_ADDR: begin
                avm_chipselect = 1'b1;
                if (op_q == OP_SNAP) begin
                    avm_address = (step == 2'd0) ? ADDR_SNAP_L : ADDR_SNAP_H;
                    if (step == 2'd0)
                        step_next = 2'd1;
                    else
                        state_next = RD_DATA;
                end else begin
                    avm_address = ADDR_STATUS;
                    state_next  = RD_DATA;
                end
            end
            RD_DATA: begin
                step_next = '0;
                gap_next  = '0;
                if (op_q == OP_SNAP)
                    state_next = DONE;
                else if (avm_readdata[STATUS_TO_BIT] || irq_wait_active)
                    state_next = CLR;
                else if (POLL_GAP == 0)
                    state_next = RD_ADDR;
                else
                    state_next = GAP;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST)
                    state_next = RD_ADDR;
                else
                    gap_next = gap_cnt + 8'd1;
            end
            IRQ_WAIT: begin
                if (irq)
                    state_next = RD_ADDR;
            end
            CLR: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = ADDR_STATUS;
                state_next     = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            step     <= '0;
            gap_cnt  <= '0;
            op_q     <= OP_START;
            period_q <= '0;
            cont_q   <= 1'b0;
            ito_q    <= 1'b0;
            snap_lo  <= '0;
            rsp_data <= '0;
        end else begin
            state   <= state_next;
            step    <= step_next;
            gap_cnt <= gap_next;
            if (accept) begin
                op_q     <= cmd_op;
                period_q <= cmd_period;
                if (cmd_op == OP_START) begin
                    cont_q <= cmd_cont;
                    ito_q  <= cmd_ito;
                end
            end
            // snap_l arrives while snap_h's address is on the bus
            if (state == RD_ADDR && op_q == OP_SNAP && step == 2'd1)
                snap_lo <= avm_readdata;
            if (state == RD_DATA) begin
                if (op_q == OP_SNAP)
                    rsp_data <= {avm_readdata, snap_lo};
                else if (avm_readdata[STATUS_TO_BIT] || irq_wait_active)
                    rsp_data <= {16'h0000, avm_readdata};
            end
        end
    end

endmodule
